// File: rtl/turbo_iteration_scheduler_if.sv
// Handshake and control bundle between the turbo iteration scheduler and its host / SISO stages.
// master = scheduler side, slave = host and engine side.
interface turbo_iteration_scheduler_if #(
   parameter int ITER_BITS = 4
);
   logic                 start;
   logic [ITER_BITS-1:0] num_iter;
   logic                 abort;
   logic                 alpha_start;
   logic                 alpha_done;
   logic                 beta_start;
   logic                 beta_done;
   logic                 ext_start;
   logic                 ext_done;
   logic                 dec_sel;
   logic [ITER_BITS-1:0] iter;
   logic                 busy;
   logic                 done;
   logic                 timeout_err;

   modport master (
      input  start, num_iter, abort, alpha_done, beta_done, ext_done,
      output alpha_start, beta_start, ext_start, dec_sel, iter, busy, done, timeout_err
   );

   modport slave (
      output start, num_iter, abort, alpha_done, beta_done, ext_done,
      input  alpha_start, beta_start, ext_start, dec_sel, iter, busy, done, timeout_err
   );
endinterface

// File: rtl/turbo_iteration_scheduler.sv
// Sequences one max-product SISO engine through turbo half-iterations:
// alpha+beta launch, join, extrinsic launch, then decoder 1/2 toggle and iteration count.
module turbo_iteration_scheduler #(
   parameter int ITER_BITS    = 4,
   parameter int TIMEOUT      = 1024,
   parameter int TIMEOUT_BITS = $clog2(TIMEOUT + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   turbo_iteration_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_AB,
      ST_EXT_LAUNCH,
      ST_WAIT_EXT,
      ST_NEXT,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ITER_BITS-1:0]    iter_q;
   logic [ITER_BITS-1:0]    limit_q;
   logic                    dec_sel_q;
   logic                    a_seen;
   logic                    b_seen;
   logic [TIMEOUT_BITS-1:0] wd_q;

   logic                    ab_complete;
   logic                    wd_expired;
   logic                    accept;
   logic [ITER_BITS:0]      iter_inc;
   logic                    last_iter;

   // A done pulse arriving in the exit cycle counts even though it was never latched.
   assign ab_complete = (a_seen | bus.alpha_done) & (b_seen | bus.beta_done);
   assign wd_expired  = (wd_q == TIMEOUT_BITS'(TIMEOUT - 1));
   assign accept      = bus.start && !bus.abort &&
                        (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
   assign iter_inc    = {1'b0, iter_q} + (ITER_BITS + 1)'(1);
   assign last_iter   = (iter_inc >= {1'b0, limit_q});

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (bus.start) state_d = ST_LAUNCH;
         ST_LAUNCH:                state_d = ST_WAIT_AB;
         ST_WAIT_AB: begin
            if (ab_complete)     state_d = ST_EXT_LAUNCH;
            else if (wd_expired) state_d = ST_ERR;
         end
         ST_EXT_LAUNCH:            state_d = ST_WAIT_EXT;
         ST_WAIT_EXT: begin
            if (bus.ext_done)    state_d = ST_NEXT;
            else if (wd_expired) state_d = ST_ERR;
         end
         ST_NEXT:                  state_d = (dec_sel_q && last_iter) ? ST_DONE : ST_LAUNCH;
         default:                  state_d = ST_IDLE;
      endcase
      if (bus.abort) state_d = ST_IDLE;
   end

   // Outputs are registered from state_d, so they equal a Moore decode of state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         iter_q          <= '0;
         limit_q         <= '0;
         dec_sel_q       <= 1'b0;
         a_seen          <= 1'b0;
         b_seen          <= 1'b0;
         wd_q            <= '0;
         bus.alpha_start <= 1'b0;
         bus.beta_start  <= 1'b0;
         bus.ext_start   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values.
         state_q         <= state_d;
         bus.alpha_start <= (state_d == ST_LAUNCH);
         bus.beta_start  <= (state_d == ST_LAUNCH);
         bus.ext_start   <= (state_d == ST_EXT_LAUNCH);
         bus.busy        <= state_d inside {ST_LAUNCH, ST_WAIT_AB, ST_EXT_LAUNCH,
                                            ST_WAIT_EXT, ST_NEXT};
         bus.done        <= (state_d == ST_DONE);
         bus.timeout_err <= (state_d == ST_ERR);

         a_seen <= (state_q == ST_WAIT_AB) && (state_d == ST_WAIT_AB) && (a_seen || bus.alpha_done);
         b_seen <= (state_q == ST_WAIT_AB) && (state_d == ST_WAIT_AB) && (b_seen || bus.beta_done);

         // Watchdog restarts from zero on every entry into a wait state.
         if ((state_q inside {ST_WAIT_AB, ST_WAIT_EXT}) && (state_d == state_q))
            wd_q <= wd_q + TIMEOUT_BITS'(1);
         else
            wd_q <= '0;

         if (bus.abort) begin
            iter_q    <= '0;
            dec_sel_q <= 1'b0;
         end else if (accept) begin
            iter_q    <= '0;
            dec_sel_q <= 1'b0;
            limit_q   <= (bus.num_iter == '0) ? ITER_BITS'(1) : bus.num_iter;
         end else if (state_q == ST_NEXT) begin
            if (!dec_sel_q) begin
               dec_sel_q <= 1'b1;
            end else begin
               iter_q <= iter_inc[ITER_BITS-1:0];
               if (!last_iter) dec_sel_q <= 1'b0;
            end
         end
      end
   end

   assign bus.iter    = iter_q;
   assign bus.dec_sel = dec_sel_q;

endmodule

// File: tb/tb_turbo_iteration_scheduler.sv
// Bench for turbo_iteration_scheduler: a latency-driven engine responder plus an arithmetic
// model of half-iteration cost, launch counts, decoder order and iteration count.
module tb_turbo_iteration_scheduler;
   localparam int ITER_BITS = 4;
   localparam int TIMEOUT   = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   turbo_iteration_scheduler_if #(.ITER_BITS(ITER_BITS)) bus ();

   turbo_iteration_scheduler #(
      .ITER_BITS (ITER_BITS),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   la[32];
   int   lb[32];
   int   le[32];
   int   a_pend, b_pend, e_pend;
   int   launches, exts, last_ab, mark;
   logic dec_seen[32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Engine model: a stage answers with a one-cycle done pulse N cycles after its launch is seen.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      bus.alpha_done = 1'b0;
      bus.beta_done  = 1'b0;
      bus.ext_done   = 1'b0;
      if (a_pend > 0) begin
         a_pend--;
         if (a_pend == 0) begin bus.alpha_done = 1'b1; last_ab = cyc; end
      end
      if (b_pend > 0) begin
         b_pend--;
         if (b_pend == 0) begin bus.beta_done = 1'b1; last_ab = cyc; end
      end
      if (e_pend > 0) begin
         e_pend--;
         if (e_pend == 0) bus.ext_done = 1'b1;
      end
      if (bus.alpha_start) begin
         check("iter_at_launch", bus.iter, launches / 2);
         check("beta_with_alpha", bus.beta_start, 1);
         if (launches < 32) begin a_pend = la[launches]; b_pend = lb[launches]; end
         launches++;
      end
      if (bus.ext_start) begin
         check("ext_after_ab", cyc, last_ab + 1);
         if (exts < 32) begin dec_seen[exts] = bus.dec_sel; e_pend = le[exts]; end
         exts++;
      end
   endtask

   task automatic clear_engine();
      a_pend = 0; b_pend = 0; e_pend = 0;
      launches = 0; exts = 0; last_ab = 0;
      bus.alpha_done = 1'b0;
      bus.beta_done  = 1'b0;
      bus.ext_done   = 1'b0;
      for (int i = 0; i < 32; i++) dec_seen[i] = 1'bx;
   endtask

   task automatic fill_lat(input int a, input int b, input int e);
      for (int i = 0; i < 32; i++) begin la[i] = a; lb[i] = b; le[i] = e; end
   endtask

   task automatic start_decode(input int n);
      clear_engine();
      bus.start    = 1'b1;
      bus.num_iter = ITER_BITS'(n);
      tick();
      bus.start    = 1'b0;
      bus.num_iter = '0;
   endtask

   // Full decode checked against the model: each half costs 3 + max(alpha, beta) + extrinsic cycles.
   task automatic run_decode(input int n, input bit poke);
      int nn;
      int halves;
      int span;
      int t0;
      bit poked;
      nn     = (n == 0) ? 1 : n;
      halves = 2 * nn;
      span   = 0;
      poked  = 1'b0;
      for (int h = 0; h < halves; h++)
         span += 3 + ((la[h] > lb[h]) ? la[h] : lb[h]) + le[h];
      start_decode(n);
      t0 = cyc;
      while (!bus.done && cyc < t0 + span + 20) begin
         if (poke && !poked && launches == 1) begin
            bus.start    = 1'b1;
            bus.num_iter = ITER_BITS'(7);
            poked        = 1'b1;
         end
         tick();
         bus.start    = 1'b0;
         bus.num_iter = '0;
      end
      check("done_time", cyc, t0 + span);
      check("launch_count", launches, halves);
      check("ext_count", exts, halves);
      for (int h = 0; h < halves; h++) check("dec_sel_order", dec_seen[h], h % 2);
      check("iter_final", bus.iter, nn);
      check("busy_after_done", bus.busy, 0);
      check("err_after_done", bus.timeout_err, 0);
      tick();
      tick();
      check("done_level", bus.done, 1);
      check("dec_sel_hold", bus.dec_sel, 1);
      check("iter_hold", bus.iter, nn);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_alpha_start"}, bus.alpha_start, 0);
      check({tag, "_beta_start"}, bus.beta_start, 0);
      check({tag, "_ext_start"}, bus.ext_start, 0);
      check({tag, "_dec_sel"}, bus.dec_sel, 0);
      check({tag, "_iter"}, bus.iter, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_timeout_err"}, bus.timeout_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.num_iter = '0;
      bus.abort    = 1'b0;
      clear_engine();
      fill_lat(3, 3, 3);
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check_all_zero("idle");

      // Single iteration, uniform latency 3.
      fill_lat(3, 3, 3);
      run_decode(1, 1'b0);

      // Skewed join: alpha early, beta late; then both in the same cycle.
      fill_lat(3, 3, 3);
      la[0] = 2; lb[0] = 5;
      la[1] = 4; lb[1] = 4;
      run_decode(1, 1'b0);

      // Iteration limit of 3 with random latencies, and a start while busy.
      for (int i = 0; i < 32; i++) begin
         la[i] = int'($urandom_range(6, 1));
         lb[i] = int'($urandom_range(6, 1));
         le[i] = int'($urandom_range(6, 1));
      end
      run_decode(3, 1'b1);

      // Zero limit behaves as one.
      fill_lat(2, 1, 2);
      run_decode(0, 1'b0);

      // Random decodes.
      repeat (4) begin
         for (int i = 0; i < 32; i++) begin
            la[i] = int'($urandom_range(8, 1));
            lb[i] = int'($urandom_range(8, 1));
            le[i] = int'($urandom_range(8, 1));
         end
         run_decode(int'($urandom_range(3, 1)), 1'b0);
      end

      // Completion exactly on the last watchdog cycle of both wait states.
      fill_lat(2, 2, 2);
      la[0] = TIMEOUT; lb[0] = 1; le[0] = TIMEOUT;
      lb[1] = TIMEOUT; le[1] = TIMEOUT;
      run_decode(1, 1'b0);

      // Watchdog in WAIT_EXT of the second half: extrinsic never answers.
      fill_lat(2, 2, 2);
      le[1] = 1000;
      start_decode(1);
      mark = cyc;
      while (exts < 2 && cyc < mark + 60) tick();
      mark = cyc;
      while (!bus.timeout_err && cyc < mark + 40) tick();
      check("wd_ext_time", cyc, mark + 1 + TIMEOUT);
      check("wd_ext_busy", bus.busy, 0);
      check("wd_ext_dec_sel", bus.dec_sel, 1);
      check("wd_ext_iter", bus.iter, 0);
      check("wd_ext_done", bus.done, 0);
      clear_engine();

      // Clean restart from ERR.
      fill_lat(3, 2, 4);
      run_decode(2, 1'b0);

      // Watchdog in WAIT_AB: alpha never answers.
      fill_lat(2, 2, 2);
      la[0] = 1000;
      start_decode(1);
      mark = cyc;
      while (!bus.timeout_err && cyc < mark + 40) tick();
      check("wd_ab_time", cyc, mark + 1 + TIMEOUT);
      check("wd_ab_ext_count", exts, 0);
      clear_engine();

      // Abort in WAIT_AB of the second half together with alpha_done and start.
      fill_lat(3, 3, 3);
      la[1] = 10; lb[1] = 10;
      start_decode(2);
      mark = cyc;
      while (launches < 2 && cyc < mark + 60) tick();
      tick(); tick(); tick();
      check("pre_abort_dec_sel", bus.dec_sel, 1);
      check("pre_abort_busy", bus.busy, 1);
      bus.abort      = 1'b1;
      bus.start      = 1'b1;
      bus.num_iter   = ITER_BITS'(5);
      bus.alpha_done = 1'b1;
      tick();
      bus.abort    = 1'b0;
      bus.start    = 1'b0;
      bus.num_iter = '0;
      check_all_zero("abort");
      clear_engine();
      repeat (4) tick();
      check("abort_no_launch", launches, 0);
      check("abort_idle_busy", bus.busy, 0);
      fill_lat(2, 4, 3);
      run_decode(2, 1'b0);

      // Asynchronous reset in WAIT_EXT of the fourth half, then spurious done pulses in IDLE.
      fill_lat(2, 2, 6);
      start_decode(2);
      mark = cyc;
      while (exts < 4 && cyc < mark + 100) tick();
      tick(); tick();
      check("pre_reset_iter", bus.iter, 1);
      check("pre_reset_dec_sel", bus.dec_sel, 1);
      check("pre_reset_busy", bus.busy, 1);
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      tick();
      clear_engine();
      reset = 1'b0;
      tick();
      repeat (3) begin
         bus.alpha_done = 1'b1;
         bus.beta_done  = 1'b1;
         bus.ext_done   = 1'b1;
         tick();
         check_all_zero("spurious_done");
      end
      clear_engine();
      fill_lat(1, 1, 1);
      run_decode(1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
